// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl
// Block-chaining front end for a DES core. Message blocks arrive one at a
// time on the s_* stream. Each block is chained (CBC) or passed through
// (ECB), handed to the core over the des_ready/des_valid handshake, and the
// core result is chained back and presented on the m_* stream. Only one
// block is in flight at any time.
//
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   cfg_*               key, IV, mode, verify and CBC enable, sampled on msg_start
//   msg_start           begins a message (honoured in IDLE only)
//   s_data/s_last/s_valid/s_ready      input block stream
//   des_ready/des_data/des_key/des_mode/des_verify/des_valid   core request side
//   des_result/des_result_valid        core result side
//   m_data/m_last/m_valid/m_ready      output block stream
//   busy                high whenever not IDLE
//   err                 sticky core-result timeout flag
//   blk_cnt             blocks delivered downstream in the current message
module des_cbc_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [63:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_mode,
  input  logic             cfg_verify,
  input  logic             cfg_cbc_en,
  input  logic             msg_start,
  input  logic [63:0]      s_data,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             des_ready,
  output logic [63:0]      des_data,
  output logic [63:0]      des_key,
  output logic             des_mode,
  output logic             des_verify,
  output logic             des_valid,
  input  logic [63:0]      des_result,
  input  logic             des_result_valid,
  output logic [63:0]      m_data,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  // The timer counts 0 .. TIMEOUT-1; a width of 1 keeps it legal when the
  // timeout is disabled or trivially small.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    ISSUE,
    WAIT_RES,
    OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        key_q, key_d;
  logic               mode_q, mode_d;
  logic               verify_q, verify_d;
  logic               cbc_q, cbc_d;
  logic [63:0]        chain_q, chain_d;
  logic [63:0]        hold_q, hold_d;
  logic [63:0]        des_data_q, des_data_d;
  logic               last_q, last_d;
  logic               des_valid_q, des_valid_d;
  logic [63:0]        m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               m_valid_q, m_valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  // State and datapath registers. Reset clears everything, so a core result
  // that straggles in after a reset finds the block in IDLE and is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      key_q       <= '0;
      mode_q      <= 1'b0;
      verify_q    <= 1'b0;
      cbc_q       <= 1'b0;
      chain_q     <= '0;
      hold_q      <= '0;
      des_data_q  <= '0;
      last_q      <= 1'b0;
      des_valid_q <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      blk_cnt_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      verify_q    <= verify_d;
      cbc_q       <= cbc_d;
      chain_q     <= chain_d;
      hold_q      <= hold_d;
      des_data_q  <= des_data_d;
      last_q      <= last_d;
      des_valid_q <= des_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      m_valid_q   <= m_valid_d;
      err_q       <= err_d;
      blk_cnt_q   <= blk_cnt_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state and datapath logic. Every register holds by default; the
  // core request strobe defaults low so it can only ever be a single pulse.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    verify_d    = verify_q;
    cbc_d       = cbc_q;
    chain_d     = chain_q;
    hold_d      = hold_q;
    des_data_d  = des_data_q;
    last_d      = last_q;
    des_valid_d = 1'b0;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q;
    err_d       = err_q;
    blk_cnt_d   = blk_cnt_q;
    timer_d     = timer_q;

    case (state_q)
      IDLE: begin
        if (msg_start) begin
          key_d     = cfg_key;
          mode_d    = cfg_mode;
          verify_d  = cfg_verify;
          cbc_d     = cfg_cbc_en;
          chain_d   = cfg_iv;
          err_d     = 1'b0;
          blk_cnt_d = '0;
          state_d   = ACCEPT;
        end
      end

      ACCEPT: begin
        if (s_valid) begin
          last_d     = s_last;
          des_data_d = (mode_q && cbc_q) ? (s_data ^ chain_q) : s_data;
          // Decrypt chaining needs this ciphertext as the next block's chain
          // value, and the core result alone cannot give it back.
          if (!mode_q && cbc_q) begin
            hold_d = s_data;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (des_ready) begin
          des_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_RES;
        end
      end

      WAIT_RES: begin
        if (des_result_valid) begin
          m_valid_d = 1'b1;
          m_last_d  = last_q;
          if (cbc_q && mode_q) begin
            m_data_d = des_result;
            chain_d  = des_result;
          end else if (cbc_q) begin
            m_data_d = des_result ^ chain_q;
            chain_d  = hold_q;
          end else begin
            m_data_d = des_result;
          end
          state_d = OUTPUT;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1))) begin
          // This is the TIMEOUT-th edge spent waiting: abandon the message.
          err_d   = 1'b1;
          chain_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      OUTPUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          blk_cnt_d = blk_cnt_q + 1'b1;
          state_d   = m_last_q ? IDLE : ACCEPT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign s_ready    = (state_q == ACCEPT);
  assign busy       = (state_q != IDLE);
  assign des_data   = des_data_q;
  assign des_key    = key_q;
  assign des_mode   = mode_q;
  assign des_verify = verify_q;
  assign des_valid  = des_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign m_valid    = m_valid_q;
  assign err        = err_q;
  assign blk_cnt    = blk_cnt_q;

endmodule
